// File: rtl/alu_serial.sv
// alu_serial: byte-serial 8-bit-style ALU widened to WIDTH bits.
// An operation is latched on start, then processed one byte per clock,
// least-significant byte first, with the carry chained between bytes.
// The result and flags are registered on the last byte and held until
// the next operation completes.
//
// Ports:
//   clk    - clock, rising-edge active
//   reset  - asynchronous active-high reset
//   start  - begin an operation (ignored while busy)
//   func   - 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 ADDW, 9-15 illegal
//   x, y   - operands
//   f_in   - incoming flags {S,Z,-,H,-,V,N,C} at bits 7,6,4,2,1,0
//   busy   - operation in progress
//   done   - one-cycle pulse when out/f are updated
//   out    - registered result
//   f      - registered result flags, same bit map as f_in
module alu_serial #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [7:0]       f_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       f
);

    localparam int unsigned NBytes = WIDTH / 8;

    localparam logic [3:0] FnAdd  = 4'd0;
    localparam logic [3:0] FnAdc  = 4'd1;
    localparam logic [3:0] FnSub  = 4'd2;
    localparam logic [3:0] FnSbc  = 4'd3;
    localparam logic [3:0] FnAnd  = 4'd4;
    localparam logic [3:0] FnXor  = 4'd5;
    localparam logic [3:0] FnOr   = 4'd6;
    localparam logic [3:0] FnCp   = 4'd7;
    localparam logic [3:0] FnAddw = 4'd8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       func_q;
    logic [7:0]       fin_q;
    logic             carry_q;
    logic [1:0]       idx_q;

    logic             init_carry;
    logic             is_sub;
    logic [7:0]       x_byte;
    logic [7:0]       y_byte;
    logic [8:0]       sum9;
    logic             c4;
    logic             c7;
    logic             c8;
    logic [7:0]       byte_res;
    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] x_rot;
    logic             last_byte;
    logic [WIDTH-1:0] out_d;
    logic [7:0]       f_d;

    // Carry seeded into byte 0, derived from the not-yet-latched inputs.
    always_comb begin
        init_carry = 1'b0;
        case (func)
            FnAdc:        init_carry = f_in[0];
            FnSub, FnCp:  init_carry = 1'b1;
            FnSbc:        init_carry = ~f_in[0];
            default:      init_carry = 1'b0;
        endcase
    end

    // One byte step of the datapath.
    always_comb begin
        is_sub = (func_q == FnSub) || (func_q == FnSbc) || (func_q == FnCp);
        x_byte = x_q[7:0];
        y_byte = is_sub ? ~y_q[7:0] : y_q[7:0];
        sum9   = {1'b0, x_byte} + {1'b0, y_byte} + {8'd0, carry_q};
        // Carries into bit 4 and bit 7 recovered from sum and operand bits.
        c4     = sum9[4] ^ x_byte[4] ^ y_byte[4];
        c7     = sum9[7] ^ x_byte[7] ^ y_byte[7];
        c8     = sum9[8];

        byte_res = sum9[7:0];
        case (func_q)
            FnAnd:   byte_res = x_q[7:0] & y_q[7:0];
            FnXor:   byte_res = x_q[7:0] ^ y_q[7:0];
            FnOr:    byte_res = x_q[7:0] | y_q[7:0];
            default: byte_res = sum9[7:0];
        endcase

        // New byte enters at the top; after NBytes steps res_full is the full word.
        res_full  = WIDTH'({byte_res, res_q} >> 8);
        // x is rotated rather than shifted so the original operand is back in
        // place on the last step (needed by CP and illegal funcs).
        x_rot     = WIDTH'({x_q[7:0], x_q} >> 8);
        last_byte = (idx_q == 2'(NBytes - 1));
    end

    // Final result and flags; only meaningful on the last byte step. The top
    // byte's bit-3 and bit-7 carries are the word's H and V sources.
    always_comb begin
        out_d = res_full;
        f_d   = 8'h00;
        case (func_q)
            FnAdd, FnAdc, FnSub, FnSbc, FnCp, FnAddw: begin
                f_d[7] = res_full[WIDTH-1];
                f_d[6] = (res_full == '0);
                f_d[4] = c4;
                f_d[2] = c7 ^ c8;
                f_d[1] = is_sub;
                f_d[0] = c8;
                if (func_q == FnCp) begin
                    out_d = x_rot;
                end
                if (func_q == FnAddw) begin
                    f_d[7] = fin_q[7];
                    f_d[6] = fin_q[6];
                    f_d[2] = fin_q[2];
                end
            end
            FnAnd, FnXor, FnOr: begin
                f_d[7] = res_full[WIDTH-1];
                f_d[6] = (res_full == '0);
                f_d[4] = 1'b1;
                f_d[2] = ^res_full;
            end
            default: begin
                out_d = x_rot;
                f_d   = fin_q;
            end
        endcase
        if (func_q <= FnAddw) begin
            f_d[5] = out_d[WIDTH-3];
            f_d[3] = out_d[WIDTH-5];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            func_q  <= 4'd0;
            fin_q   <= 8'h00;
            carry_q <= 1'b0;
            idx_q   <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            f       <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q     <= x;
                        y_q     <= y;
                        res_q   <= '0;
                        func_q  <= func;
                        fin_q   <= f_in;
                        carry_q <= init_carry;
                        idx_q   <= 2'd0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    x_q     <= x_rot;
                    y_q     <= y_q >> 8;
                    res_q   <= res_full;
                    carry_q <= c8;
                    idx_q   <= idx_q + 2'd1;
                    if (last_byte) begin
                        out     <= out_d;
                        f       <= f_d;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
